axil_rr_arbiter: RTL and testbench

Two-master, one-slave AXI4-Lite arbiter that shares a single slave port (the main AXILiteMemory) between the CPU (`picorv32_axi`) and the GraphicSystem master. Arbitration is round-robin. Exactly one transaction (read or write) is in flight at a time. The block sits between the two masters and the memory slave, in place of a full interconnect path when only memory is shared.

---
 rtl/axil_rr_arbiter.sv | 237 +++++++++++++++++++++++
 tb/tb_axil_rr_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_rr_arbiter.sv
// axil_rr_arbiter
// Shares one AXI4-Lite slave (main memory) between two masters: the CPU and
// the GraphicSystem. Round-robin arbitration with one transaction in flight.
//
// Ports:
//   aclk, aresetn      clock (rising edge), asynchronous active-low reset
//   s_axil_*           master-side channels, master i in slice i (0=CPU, 1=GS)
//   m_axil_*           slave-side channels
//   grant              one-hot current owner, 0 when idle
//   busy               high while a transaction is in flight
module axil_rr_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    // master side
    input  logic [2*ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic [5:0]                s_axil_awprot,
    input  logic [1:0]                s_axil_awvalid,
    output logic [1:0]                s_axil_awready,
    input  logic [2*DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [2*STRB_WIDTH-1:0]   s_axil_wstrb,
    input  logic [1:0]                s_axil_wvalid,
    output logic [1:0]                s_axil_wready,
    output logic [3:0]                s_axil_bresp,
    output logic [1:0]                s_axil_bvalid,
    input  logic [1:0]                s_axil_bready,
    input  logic [2*ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic [5:0]                s_axil_arprot,
    input  logic [1:0]                s_axil_arvalid,
    output logic [1:0]                s_axil_arready,
    output logic [2*DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [3:0]                s_axil_rresp,
    output logic [1:0]                s_axil_rvalid,
    input  logic [1:0]                s_axil_rready,
    // slave side
    output logic [ADDR_WIDTH-1:0]     m_axil_awaddr,
    output logic [2:0]                m_axil_awprot,
    output logic                      m_axil_awvalid,
    input  logic                      m_axil_awready,
    output logic [DATA_WIDTH-1:0]     m_axil_wdata,
    output logic [STRB_WIDTH-1:0]     m_axil_wstrb,
    output logic                      m_axil_wvalid,
    input  logic                      m_axil_wready,
    input  logic [1:0]                m_axil_bresp,
    input  logic                      m_axil_bvalid,
    output logic                      m_axil_bready,
    output logic [ADDR_WIDTH-1:0]     m_axil_araddr,
    output logic [2:0]                m_axil_arprot,
    output logic                      m_axil_arvalid,
    input  logic                      m_axil_arready,
    input  logic [DATA_WIDTH-1:0]     m_axil_rdata,
    input  logic [1:0]                m_axil_rresp,
    input  logic                      m_axil_rvalid,
    output logic                      m_axil_rready,
    // status
    output logic [1:0]                grant,
    output logic                      busy
);

    typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA} state_t;

    state_t state_q, state_d;
    logic   owner_q, owner_d;
    logic   ptr_q, ptr_d;
    logic   aw_done_q, aw_done_d;
    logic   w_done_q, w_done_d;

    // Owner-selected view of the master-side inputs
    logic [ADDR_WIDTH-1:0] own_awaddr, own_araddr;
    logic [2:0]            own_awprot, own_arprot;
    logic [DATA_WIDTH-1:0] own_wdata;
    logic [STRB_WIDTH-1:0] own_wstrb;
    logic                  own_awvalid, own_wvalid, own_arvalid;
    logic                  own_bready, own_rready;

    assign own_awaddr  = owner_q ? s_axil_awaddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : s_axil_awaddr[ADDR_WIDTH-1:0];
    assign own_araddr  = owner_q ? s_axil_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : s_axil_araddr[ADDR_WIDTH-1:0];
    assign own_awprot  = owner_q ? s_axil_awprot[5:3] : s_axil_awprot[2:0];
    assign own_arprot  = owner_q ? s_axil_arprot[5:3] : s_axil_arprot[2:0];
    assign own_wdata   = owner_q ? s_axil_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : s_axil_wdata[DATA_WIDTH-1:0];
    assign own_wstrb   = owner_q ? s_axil_wstrb[2*STRB_WIDTH-1:STRB_WIDTH] : s_axil_wstrb[STRB_WIDTH-1:0];
    assign own_awvalid = s_axil_awvalid[owner_q];
    assign own_wvalid  = s_axil_wvalid[owner_q];
    assign own_arvalid = s_axil_arvalid[owner_q];
    assign own_bready  = s_axil_bready[owner_q];
    assign own_rready  = s_axil_rready[owner_q];

    // Owner-side return signals before they are steered to the right slice
    logic                  awready_own, wready_own, arready_own;
    logic                  bvalid_own, rvalid_own;
    logic [1:0]            bresp_own, rresp_own;
    logic [DATA_WIDTH-1:0] rdata_own;

    // State register; reset abandons any in-flight transaction immediately
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            ptr_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Channel muxing: only the channel(s) of the current phase are opened,
    // everything else is held at zero. AW/W are masked once their beat has
    // been accepted so the slave never sees a duplicate beat.
    always_comb begin
        m_axil_awaddr  = '0;
        m_axil_awprot  = '0;
        m_axil_awvalid = 1'b0;
        m_axil_wdata   = '0;
        m_axil_wstrb   = '0;
        m_axil_wvalid  = 1'b0;
        m_axil_bready  = 1'b0;
        m_axil_araddr  = '0;
        m_axil_arprot  = '0;
        m_axil_arvalid = 1'b0;
        m_axil_rready  = 1'b0;
        awready_own    = 1'b0;
        wready_own     = 1'b0;
        arready_own    = 1'b0;
        bvalid_own     = 1'b0;
        bresp_own      = '0;
        rvalid_own     = 1'b0;
        rresp_own      = '0;
        rdata_own      = '0;
        unique case (state_q)
            WR: begin
                m_axil_awaddr  = own_awaddr;
                m_axil_awprot  = own_awprot;
                m_axil_awvalid = own_awvalid & ~aw_done_q;
                m_axil_wdata   = own_wdata;
                m_axil_wstrb   = own_wstrb;
                m_axil_wvalid  = own_wvalid & ~w_done_q;
                awready_own    = m_axil_awready & ~aw_done_q;
                wready_own     = m_axil_wready & ~w_done_q;
            end
            WR_RESP: begin
                m_axil_bready = own_bready;
                bvalid_own    = m_axil_bvalid;
                bresp_own     = m_axil_bresp;
            end
            RD_ADDR: begin
                m_axil_araddr  = own_araddr;
                m_axil_arprot  = own_arprot;
                m_axil_arvalid = own_arvalid;
                arready_own    = m_axil_arready;
            end
            RD_DATA: begin
                m_axil_rready = own_rready;
                rvalid_own    = m_axil_rvalid;
                rresp_own     = m_axil_rresp;
                rdata_own     = m_axil_rdata;
            end
            default: ;
        endcase
    end

    // Steer return signals to the owner's slice; the other master sees zeros
    assign s_axil_awready = owner_q ? {awready_own, 1'b0} : {1'b0, awready_own};
    assign s_axil_wready  = owner_q ? {wready_own, 1'b0}  : {1'b0, wready_own};
    assign s_axil_arready = owner_q ? {arready_own, 1'b0} : {1'b0, arready_own};
    assign s_axil_bvalid  = owner_q ? {bvalid_own, 1'b0}  : {1'b0, bvalid_own};
    assign s_axil_rvalid  = owner_q ? {rvalid_own, 1'b0}  : {1'b0, rvalid_own};
    assign s_axil_bresp   = owner_q ? {bresp_own, 2'b00}  : {2'b00, bresp_own};
    assign s_axil_rresp   = owner_q ? {rresp_own, 2'b00}  : {2'b00, rresp_own};
    assign s_axil_rdata   = owner_q ? {rdata_own, {DATA_WIDTH{1'b0}}} : {{DATA_WIDTH{1'b0}}, rdata_own};

    assign busy  = (state_q != IDLE);
    assign grant = busy ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

    // Next-state: round-robin pick in IDLE starting at ptr, write beats read
    // within the winner; ptr moves to the other master when a transaction ends.
    always_comb begin
        logic [1:0] req;
        logic       winner;
        logic       aw_hs, w_hs;
        state_d   = state_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        req       = s_axil_awvalid | s_axil_arvalid;
        winner    = req[ptr_q] ? ptr_q : ~ptr_q;
        aw_hs     = m_axil_awvalid & m_axil_awready;
        w_hs      = m_axil_wvalid & m_axil_wready;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    owner_d   = winner;
                    state_d   = s_axil_awvalid[winner] ? WR : RD_ADDR;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            WR: begin
                if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                    state_d   = WR_RESP;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else begin
                    aw_done_d = aw_done_q | aw_hs;
                    w_done_d  = w_done_q | w_hs;
                end
            end
            WR_RESP: begin
                if (m_axil_bvalid && own_bready) begin
                    state_d = IDLE;
                    ptr_d   = ~owner_q;
                end
            end
            RD_ADDR: begin
                if (own_arvalid && m_axil_arready) begin
                    state_d = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m_axil_rvalid && own_rready) begin
                    state_d = IDLE;
                    ptr_d   = ~owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_axil_rr_arbiter.sv
// tb_axil_rr_arbiter
// Directed bench for axil_rr_arbiter: a table of per-cycle vectors covering
// a single write, read contention and write-over-read priority, plus
// hand-written sequences for reset, W-before-AW and mid-transaction reset.
module tb_axil_rr_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic              aclk;
    logic              aresetn;
    logic [2*AW-1:0]   s_awaddr;
    logic [5:0]        s_awprot;
    logic [1:0]        s_awvalid;
    logic [1:0]        s_awready;
    logic [2*DW-1:0]   s_wdata;
    logic [2*SW-1:0]   s_wstrb;
    logic [1:0]        s_wvalid;
    logic [1:0]        s_wready;
    logic [3:0]        s_bresp;
    logic [1:0]        s_bvalid;
    logic [1:0]        s_bready;
    logic [2*AW-1:0]   s_araddr;
    logic [5:0]        s_arprot;
    logic [1:0]        s_arvalid;
    logic [1:0]        s_arready;
    logic [2*DW-1:0]   s_rdata;
    logic [3:0]        s_rresp;
    logic [1:0]        s_rvalid;
    logic [1:0]        s_rready;
    logic [AW-1:0]     m_awaddr;
    logic [2:0]        m_awprot;
    logic              m_awvalid;
    logic              m_awready;
    logic [DW-1:0]     m_wdata;
    logic [SW-1:0]     m_wstrb;
    logic              m_wvalid;
    logic              m_wready;
    logic [1:0]        m_bresp;
    logic              m_bvalid;
    logic              m_bready;
    logic [AW-1:0]     m_araddr;
    logic [2:0]        m_arprot;
    logic              m_arvalid;
    logic              m_arready;
    logic [DW-1:0]     m_rdata;
    logic [1:0]        m_rresp;
    logic              m_rvalid;
    logic              m_rready;
    logic [1:0]        grant;
    logic              busy;

    int passed = 0;
    int total  = 0;

    axil_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axil_awaddr(s_awaddr), .s_axil_awprot(s_awprot), .s_axil_awvalid(s_awvalid),
        .s_axil_awready(s_awready), .s_axil_wdata(s_wdata), .s_axil_wstrb(s_wstrb),
        .s_axil_wvalid(s_wvalid), .s_axil_wready(s_wready), .s_axil_bresp(s_bresp),
        .s_axil_bvalid(s_bvalid), .s_axil_bready(s_bready), .s_axil_araddr(s_araddr),
        .s_axil_arprot(s_arprot), .s_axil_arvalid(s_arvalid), .s_axil_arready(s_arready),
        .s_axil_rdata(s_rdata), .s_axil_rresp(s_rresp), .s_axil_rvalid(s_rvalid),
        .s_axil_rready(s_rready),
        .m_axil_awaddr(m_awaddr), .m_axil_awprot(m_awprot), .m_axil_awvalid(m_awvalid),
        .m_axil_awready(m_awready), .m_axil_wdata(m_wdata), .m_axil_wstrb(m_wstrb),
        .m_axil_wvalid(m_wvalid), .m_axil_wready(m_wready), .m_axil_bresp(m_bresp),
        .m_axil_bvalid(m_bvalid), .m_axil_bready(m_bready), .m_axil_araddr(m_araddr),
        .m_axil_arprot(m_arprot), .m_axil_arvalid(m_arvalid), .m_axil_arready(m_arready),
        .m_axil_rdata(m_rdata), .m_axil_rresp(m_rresp), .m_axil_rvalid(m_rvalid),
        .m_axil_rready(m_rready),
        .grant(grant), .busy(busy)
    );

    // 10 ns clock
    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // One table row is one clock cycle: inputs applied just after the rising
    // edge, outputs checked on the following falling edge.
    typedef struct {
        logic       rst;
        logic [1:0] awv, wv, arv;
        logic       s_awr, s_wr, s_arr, s_bv, s_rv;
        logic [1:0] e_grant;
        logic       e_busy, e_mawv, e_mwv, e_marv;
        logic [1:0] e_awr, e_wr, e_arr, e_bv, e_rv;
        logic [31:0] e_rd0, e_rd1;
        string      name;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkv(logic rst, logic [1:0] awv, logic [1:0] wv, logic [1:0] arv,
                                 logic s_awr, logic s_wr, logic s_arr, logic s_bv, logic s_rv,
                                 logic [1:0] e_grant, logic e_busy, logic e_mawv, logic e_mwv,
                                 logic e_marv, logic [1:0] e_awr, logic [1:0] e_wr,
                                 logic [1:0] e_arr, logic [1:0] e_bv, logic [1:0] e_rv,
                                 logic [31:0] e_rd0, logic [31:0] e_rd1, string name);
        vec_t v;
        v.rst = rst; v.awv = awv; v.wv = wv; v.arv = arv;
        v.s_awr = s_awr; v.s_wr = s_wr; v.s_arr = s_arr; v.s_bv = s_bv; v.s_rv = s_rv;
        v.e_grant = e_grant; v.e_busy = e_busy; v.e_mawv = e_mawv; v.e_mwv = e_mwv;
        v.e_marv = e_marv; v.e_awr = e_awr; v.e_wr = e_wr; v.e_arr = e_arr;
        v.e_bv = e_bv; v.e_rv = e_rv; v.e_rd0 = e_rd0; v.e_rd1 = e_rd1; v.name = name;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        s_awvalid = v.awv;
        s_wvalid  = v.wv;
        s_arvalid = v.arv;
        m_awready = v.s_awr;
        m_wready  = v.s_wr;
        m_arready = v.s_arr;
        m_bvalid  = v.s_bv;
        m_rvalid  = v.s_rv;
    endtask

    // Called just after a rising edge; returns just after the next one with
    // reset released and all handshake inputs idle.
    task automatic doReset();
        aresetn   = 1'b0;
        s_awvalid = 2'b00; s_wvalid = 2'b00; s_arvalid = 2'b00;
        m_awready = 1'b0;  m_wready = 1'b0;  m_arready = 1'b0;
        m_bvalid  = 1'b0;  m_rvalid = 1'b0;
        s_bready  = 2'b11; s_rready = 2'b11;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    task automatic checkRow(input vec_t v);
        checkOutput({v.name, ".grant"},     32'(grant),     32'(v.e_grant));
        checkOutput({v.name, ".busy"},      32'(busy),      32'(v.e_busy));
        checkOutput({v.name, ".m_awvalid"}, 32'(m_awvalid), 32'(v.e_mawv));
        checkOutput({v.name, ".m_wvalid"},  32'(m_wvalid),  32'(v.e_mwv));
        checkOutput({v.name, ".m_arvalid"}, 32'(m_arvalid), 32'(v.e_marv));
        checkOutput({v.name, ".s_awready"}, 32'(s_awready), 32'(v.e_awr));
        checkOutput({v.name, ".s_wready"},  32'(s_wready),  32'(v.e_wr));
        checkOutput({v.name, ".s_arready"}, 32'(s_arready), 32'(v.e_arr));
        checkOutput({v.name, ".s_bvalid"},  32'(s_bvalid),  32'(v.e_bv));
        checkOutput({v.name, ".s_rvalid"},  32'(s_rvalid),  32'(v.e_rv));
        checkOutput({v.name, ".rdata0"},    s_rdata[31:0],  v.e_rd0);
        checkOutput({v.name, ".rdata1"},    s_rdata[63:32], v.e_rd1);
    endtask

    initial begin
        // static payloads: master 0 = CPU, master 1 = GS
        s_awaddr = {32'h0000_0020, 32'h0000_0010};
        s_awprot = 6'b000_000;
        s_wdata  = {32'hCAFE_F00D, 32'hDEAD_BEEF};
        s_wstrb  = {4'h3, 4'hF};
        s_araddr = {32'h0000_0200, 32'h0000_0100};
        s_arprot = 6'b000_000;
        s_bready = 2'b11;
        s_rready = 2'b11;
        m_bresp  = 2'b00;
        m_rresp  = 2'b00;
        m_rdata  = 32'h0000_1234;

        // Reset held with every valid asserted: everything must stay quiet
        aresetn   = 1'b0;
        s_awvalid = 2'b11; s_wvalid = 2'b11; s_arvalid = 2'b11;
        m_awready = 1'b1;  m_wready = 1'b1;  m_arready = 1'b1;
        m_bvalid  = 1'b1;  m_rvalid = 1'b1;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        checkOutput("rst.grant",     32'(grant),     32'd0);
        checkOutput("rst.busy",      32'(busy),      32'd0);
        checkOutput("rst.m_awvalid", 32'(m_awvalid), 32'd0);
        checkOutput("rst.m_wvalid",  32'(m_wvalid),  32'd0);
        checkOutput("rst.m_arvalid", 32'(m_arvalid), 32'd0);
        checkOutput("rst.m_bready",  32'(m_bready),  32'd0);
        checkOutput("rst.m_rready",  32'(m_rready),  32'd0);
        checkOutput("rst.s_awready", 32'(s_awready), 32'd0);
        checkOutput("rst.s_wready",  32'(s_wready),  32'd0);
        checkOutput("rst.s_arready", 32'(s_arready), 32'd0);
        checkOutput("rst.s_bvalid",  32'(s_bvalid),  32'd0);
        checkOutput("rst.s_rvalid",  32'(s_rvalid),  32'd0);
        checkOutput("rst.s_rdata0",  s_rdata[31:0],  32'd0);
        checkOutput("rst.m_awaddr",  m_awaddr,       32'd0);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(negedge aclk);
        checkOutput("rel.grant_before_edge", 32'(grant), 32'd0);
        @(negedge aclk);
        checkOutput("rel.grant_after_edge",  32'(grant), 32'h1);
        checkOutput("rel.busy_after_edge",   32'(busy),  32'h1);
        @(posedge aclk);
        #1;

        // Single CPU write
        vecs.push_back(mkv(1, 2'b01, 2'b01, 2'b00, 1,1,0,0,0, 2'b00,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,0, "wr_idle"));
        vecs.push_back(mkv(0, 2'b01, 2'b01, 2'b00, 1,1,0,0,0, 2'b01,1,1,1,0, 2'b01,2'b01,2'b00,2'b00,2'b00, 0,0, "wr_awdata"));
        vecs.push_back(mkv(0, 2'b00, 2'b00, 2'b00, 1,1,0,0,0, 2'b01,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,0, "wr_resp_wait"));
        vecs.push_back(mkv(0, 2'b00, 2'b00, 2'b00, 1,1,0,1,0, 2'b01,1,0,0,0, 2'b00,2'b00,2'b00,2'b01,2'b00, 0,0, "wr_resp"));
        vecs.push_back(mkv(0, 2'b00, 2'b00, 2'b00, 1,1,0,0,0, 2'b00,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,0, "wr_gap"));
        // Read contention: both masters read every cycle
        vecs.push_back(mkv(1, 2'b00, 2'b00, 2'b11, 0,0,1,0,1, 2'b00,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,0, "rd_idle"));
        vecs.push_back(mkv(0, 2'b00, 2'b00, 2'b11, 0,0,1,0,1, 2'b01,1,0,0,1, 2'b00,2'b00,2'b01,2'b00,2'b00, 0,0, "rd_m0_addr"));
        vecs.push_back(mkv(0, 2'b00, 2'b00, 2'b11, 0,0,1,0,1, 2'b01,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b01, 32'h1234,0, "rd_m0_data"));
        vecs.push_back(mkv(0, 2'b00, 2'b00, 2'b11, 0,0,1,0,1, 2'b00,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,0, "rd_gap1"));
        vecs.push_back(mkv(0, 2'b00, 2'b00, 2'b11, 0,0,1,0,1, 2'b10,1,0,0,1, 2'b00,2'b00,2'b10,2'b00,2'b00, 0,0, "rd_m1_addr"));
        vecs.push_back(mkv(0, 2'b00, 2'b00, 2'b11, 0,0,1,0,1, 2'b10,1,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b10, 0,32'h1234, "rd_m1_data"));
        vecs.push_back(mkv(0, 2'b00, 2'b00, 2'b11, 0,0,1,0,1, 2'b00,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,0, "rd_gap2"));
        vecs.push_back(mkv(0, 2'b00, 2'b00, 2'b11, 0,0,1,0,1, 2'b01,1,0,0,1, 2'b00,2'b00,2'b01,2'b00,2'b00, 0,0, "rd_m0_again"));
        // Write beats read within the same master
        vecs.push_back(mkv(1, 2'b01, 2'b01, 2'b01, 1,1,1,1,0, 2'b00,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,0, "pri_idle"));
        vecs.push_back(mkv(0, 2'b01, 2'b01, 2'b01, 1,1,1,1,0, 2'b01,1,1,1,0, 2'b01,2'b01,2'b00,2'b00,2'b00, 0,0, "pri_write"));
        vecs.push_back(mkv(0, 2'b00, 2'b00, 2'b01, 1,1,1,1,0, 2'b01,1,0,0,0, 2'b00,2'b00,2'b00,2'b01,2'b00, 0,0, "pri_bresp"));
        vecs.push_back(mkv(0, 2'b00, 2'b00, 2'b01, 1,1,1,1,0, 2'b00,0,0,0,0, 2'b00,2'b00,2'b00,2'b00,2'b00, 0,0, "pri_gap"));
        vecs.push_back(mkv(0, 2'b00, 2'b00, 2'b01, 1,1,1,0,0, 2'b01,1,0,0,1, 2'b00,2'b00,2'b01,2'b00,2'b00, 0,0, "pri_read"));

        foreach (vecs[i]) begin
            if (vecs[i].rst) doReset();
            applyStimulus(vecs[i]);
            @(negedge aclk);
            checkRow(vecs[i]);
            @(posedge aclk);
            #1;
        end

        // W before AW: GS holds wvalid alone (no request), then raises
        // awvalid while the slave delays awready
        doReset();
        s_wvalid = 2'b10;
        m_wready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge aclk);
            checkOutput("wfirst.idle_grant",  32'(grant),    32'd0);
            checkOutput("wfirst.idle_wvalid", 32'(m_wvalid), 32'd0);
            @(posedge aclk);
            #1;
        end
        s_awvalid = 2'b10;
        @(posedge aclk);
        #1;
        @(negedge aclk);
        checkOutput("wfirst.grant",     32'(grant),     32'h2);
        checkOutput("wfirst.m_awvalid", 32'(m_awvalid), 32'd1);
        checkOutput("wfirst.m_wvalid",  32'(m_wvalid),  32'd1);
        checkOutput("wfirst.m_awaddr",  m_awaddr,       32'h0000_0020);
        checkOutput("wfirst.m_wdata",   m_wdata,        32'hCAFE_F00D);
        checkOutput("wfirst.m_wstrb",   32'(m_wstrb),   32'h3);
        checkOutput("wfirst.s_wready",  32'(s_wready),  32'h2);
        checkOutput("wfirst.s_awready", 32'(s_awready), 32'h0);
        @(posedge aclk);
        #1;
        m_bvalid = 1'b1;
        @(negedge aclk);
        checkOutput("wfirst.no_dup_w",   32'(m_wvalid),  32'd0);
        checkOutput("wfirst.wready_off", 32'(s_wready),  32'h0);
        checkOutput("wfirst.still_wr",   32'(s_bvalid),  32'h0);
        checkOutput("wfirst.busy",       32'(busy),      32'd1);
        @(posedge aclk);
        #1;
        m_awready = 1'b1;
        @(negedge aclk);
        checkOutput("wfirst.aw_hs",      32'(s_awready), 32'h2);
        checkOutput("wfirst.aw_hs_w",    32'(m_wvalid),  32'd0);
        @(posedge aclk);
        #1;
        s_awvalid = 2'b00;
        s_wvalid  = 2'b00;
        @(negedge aclk);
        checkOutput("wfirst.bvalid",     32'(s_bvalid),  32'h2);
        checkOutput("wfirst.m_bready",   32'(m_bready),  32'd1);
        checkOutput("wfirst.resp_awv",   32'(m_awvalid), 32'd0);
        @(posedge aclk);
        #1;
        @(negedge aclk);
        checkOutput("wfirst.done_busy",  32'(busy),      32'd0);
        @(posedge aclk);
        #1;

        // Reset asserted while CPU sits in RD_DATA with slave rvalid high
        doReset();
        s_arvalid = 2'b01;
        s_rready  = 2'b00;
        m_arready = 1'b1;
        m_rvalid  = 1'b1;
        m_rdata   = 32'h0000_55AA;
        @(posedge aclk);
        #1;
        @(posedge aclk);
        #1;
        s_arvalid = 2'b00;
        @(negedge aclk);
        checkOutput("midrst.rvalid_before", 32'(s_rvalid), 32'h1);
        checkOutput("midrst.rdata_before",  s_rdata[31:0], 32'h0000_55AA);
        aresetn = 1'b0;
        #1;
        checkOutput("midrst.rvalid_async",  32'(s_rvalid), 32'h0);
        checkOutput("midrst.rdata_async",   s_rdata[31:0], 32'h0);
        checkOutput("midrst.busy_async",    32'(busy),     32'd0);
        checkOutput("midrst.grant_async",   32'(grant),    32'd0);
        @(posedge aclk);
        #1;
        aresetn  = 1'b1;
        s_rready = 2'b11;
        @(negedge aclk);
        checkOutput("midrst.idle_after",    32'(busy),     32'd0);
        @(negedge aclk);
        checkOutput("midrst.still_idle",    32'(grant),    32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
